// File: rtl/rom_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_access_arbiter_if
// Description : Bundle of the requester handshake and ROM bus signals used
//               by rom_access_arbiter.
//               slave  : arbiter view (drives ACKs, RDATA, BUSY, ROM_*)
//               master : environment view (drives REQs, ADDRs, ROM_DATA)
//               Signals:
//                 REQ0/ADDR0, REQ1/ADDR1 : requester read requests
//                 ACK0/ACK1, RDATA       : one-cycle ack with read data
//                 BUSY                   : arbiter not idle
//                 ROM_ADDR, ROM_CS (active-low), ROM_OE, ROM_DATA : ROM bus
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_access_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5
);
    logic             REQ0;
    logic [DEPTH-1:0] ADDR0;
    logic             REQ1;
    logic [DEPTH-1:0] ADDR1;
    logic             ACK0;
    logic             ACK1;
    logic [WIDTH-1:0] RDATA;
    logic             BUSY;
    logic [DEPTH-1:0] ROM_ADDR;
    logic             ROM_CS;
    logic             ROM_OE;
    logic [WIDTH-1:0] ROM_DATA;

    modport slave (
        input  REQ0, ADDR0, REQ1, ADDR1, ROM_DATA,
        output ACK0, ACK1, RDATA, BUSY, ROM_ADDR, ROM_CS, ROM_OE
    );

    modport master (
        output REQ0, ADDR0, REQ1, ADDR1, ROM_DATA,
        input  ACK0, ACK1, RDATA, BUSY, ROM_ADDR, ROM_CS, ROM_OE
    );
endinterface
`default_nettype wire

// File: rtl/rom_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_access_arbiter
// Description : Round-robin arbiter sharing one asynchronous-read ROM between
//               two requesters. Sequences the ROM chip select, output enable
//               and address, registers the returned word and acknowledges the
//               granted requester with a one-cycle pulse.
//               Ports:
//                 CLK : system clock, rising edge
//                 RST : asynchronous active-high reset
//                 bus : rom_access_arbiter_if.slave (requesters + ROM bus)
//               Parameters:
//                 WIDTH       : ROM word width
//                 DEPTH       : ROM address width
//                 WAIT_STATES : extra CS/OE cycles before sampling (0..15)
// Revision    : 1.0 - initial release
// ============================================================================
module rom_access_arbiter #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 5,
    parameter int WAIT_STATES = 0
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    rom_access_arbiter_if.slave   bus
);

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
            $error("rom_access_arbiter: WAIT_STATES must be in 0..15");
        end
    endgenerate

    localparam logic [3:0] C_WAIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state;
    logic [DEPTH-1:0]   r_addr,  w_addr;
    logic               r_cs,    w_cs;
    logic               r_oe,    w_oe;
    logic [WIDTH-1:0]   r_rdata, w_rdata;
    logic               r_ack0,  w_ack0;
    logic               r_ack1,  w_ack1;
    logic               r_busy,  w_busy;
    logic [3:0]         r_cnt,   w_cnt;
    logic               r_last,  w_last;   // id of the most recently served requester
    logic               r_gid,   w_gid;    // id of the requester owning the current access
    logic               w_grant;

    // ------------------------------------------------------------------------
    // State register (all outputs are registered here as well)
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_cs    <= 1'b1;
            r_oe    <= 1'b0;
            r_rdata <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= 4'd0;
            r_last  <= 1'b1;   // so requester 0 wins the first tie
            r_gid   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_cs    <= w_cs;
            r_oe    <= w_oe;
            r_rdata <= w_rdata;
            r_ack0  <= w_ack0;
            r_ack1  <= w_ack1;
            r_busy  <= w_busy;
            r_cnt   <= w_cnt;
            r_last  <= w_last;
            r_gid   <= w_gid;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_cs    = r_cs;
        w_oe    = r_oe;
        w_rdata = r_rdata;
        w_ack0  = 1'b0;    // acknowledges are single-cycle pulses
        w_ack1  = 1'b0;
        w_cnt   = r_cnt;
        w_last  = r_last;
        w_gid   = r_gid;
        // Single requester wins outright; on a tie the one not served last wins.
        w_grant = (bus.REQ0 && bus.REQ1) ? ~r_last : bus.REQ1;

        case (r_state)
            ST_IDLE: begin
                w_cs = 1'b1;
                w_oe = 1'b0;
                if (bus.REQ0 || bus.REQ1) begin
                    w_gid   = w_grant;
                    w_addr  = w_grant ? bus.ADDR1 : bus.ADDR0;
                    w_cs    = 1'b0;
                    w_oe    = 1'b1;
                    w_cnt   = C_WAIT;
                    w_state = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (r_cnt != 4'd0) begin
                    w_cnt = r_cnt - 4'd1;
                end else begin
                    w_rdata = bus.ROM_DATA;
                    w_cs    = 1'b1;
                    w_oe    = 1'b0;
                    w_ack0  = ~r_gid;
                    w_ack1  = r_gid;
                    w_last  = r_gid;
                    w_state = ST_DONE;
                end
            end

            ST_DONE: begin
                // No arbitration here: gives the requester one cycle to drop
                // or renew REQ before IDLE looks at it again.
                w_state = ST_IDLE;
            end

            default: begin
                w_cs    = 1'b1;
                w_oe    = 1'b0;
                w_state = ST_IDLE;
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    assign bus.ACK0     = r_ack0;
    assign bus.ACK1     = r_ack1;
    assign bus.RDATA    = r_rdata;
    assign bus.BUSY     = r_busy;
    assign bus.ROM_ADDR = r_addr;
    assign bus.ROM_CS   = r_cs;
    assign bus.ROM_OE   = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_rom_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_access_arbiter
// Description : Self-checking bench for rom_access_arbiter. Three instances
//               with WAIT_STATES = 0, 2 and 3 share clock and reset; each has
//               its own ROM model. Expected acknowledges are queued by the
//               stimulus and popped by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_access_arbiter;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rom_access_arbiter_if #(.WIDTH(8), .DEPTH(5)) bus0 ();
    rom_access_arbiter_if #(.WIDTH(8), .DEPTH(5)) bus2 ();
    rom_access_arbiter_if #(.WIDTH(8), .DEPTH(5)) bus3 ();

    rom_access_arbiter #(.WIDTH(8), .DEPTH(5), .WAIT_STATES(0)) dut0 (
        .CLK(clk), .RST(rst), .bus(bus0.slave));
    rom_access_arbiter #(.WIDTH(8), .DEPTH(5), .WAIT_STATES(2)) dut2 (
        .CLK(clk), .RST(rst), .bus(bus2.slave));
    rom_access_arbiter #(.WIDTH(8), .DEPTH(5), .WAIT_STATES(3)) dut3 (
        .CLK(clk), .RST(rst), .bus(bus3.slave));

    // ROM contents: a few fixed words, everything else is addr ^ 8'h5A
    function automatic logic [7:0] rom_word(input logic [4:0] a);
        case (a)
            5'd3:    return 8'h11;
            5'd5:    return 8'hA5;
            5'd7:    return 8'h22;
            5'd31:   return 8'hFF;
            default: return 8'(a) ^ 8'h5A;
        endcase
    endfunction

    assign bus0.ROM_DATA = bus0.ROM_CS ? 8'h00 : rom_word(bus0.ROM_ADDR);
    assign bus2.ROM_DATA = bus2.ROM_CS ? 8'h00 : rom_word(bus2.ROM_ADDR);
    assign bus3.ROM_DATA = bus3.ROM_CS ? 8'h00 : rom_word(bus3.ROM_ADDR);

    typedef struct {
        int         dut;
        int         port;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    task automatic push(input int d, input int p, input logic [7:0] v);
        exp_t e;
        e.dut  = d;
        e.port = p;
        e.data = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_ack(input int d, input int p);
        case (d)
            0:       return p != 0 ? bus0.ACK1 : bus0.ACK0;
            1:       return p != 0 ? bus2.ACK1 : bus2.ACK0;
            default: return p != 0 ? bus3.ACK1 : bus3.ACK0;
        endcase
    endfunction

    function automatic logic [7:0] get_rdata(input int d);
        case (d)
            0:       return bus0.RDATA;
            1:       return bus2.RDATA;
            default: return bus3.RDATA;
        endcase
    endfunction

    function automatic logic [1:0] get_cs_oe(input int d);
        case (d)
            0:       return {bus0.ROM_CS, bus0.ROM_OE};
            1:       return {bus2.ROM_CS, bus2.ROM_OE};
            default: return {bus3.ROM_CS, bus3.ROM_OE};
        endcase
    endfunction

    // Instance index 0,1,2 maps to scoreboard dut id 0,2,3
    function automatic int dut_id(input int idx);
        return idx == 0 ? 0 : (idx == 1 ? 2 : 3);
    endfunction

    // ------------------------------------------------------------------------
    // Monitor: pops an expectation for every acknowledge any instance shows
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic a0, a1;
            logic [1:0] csoe;
            a0   = get_ack(i, 0);
            a1   = get_ack(i, 1);
            csoe = get_cs_oe(i);
            if (csoe[1] == 1'b0)
                check($sformatf("cs_implies_oe_d%0d", dut_id(i)), 32'(csoe[0]), 32'd1);
            if (a0 || a1) begin
                exp_t e;
                check($sformatf("ack_exclusive_d%0d", dut_id(i)), 32'(a0 && a1), 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: d%0d ack0=%0b ack1=%0b, expected none", dut_id(i), a0, a1);
                end else begin
                    e = sb.pop_front();
                    check("ack_dut",   32'(dut_id(i)),   32'(e.dut));
                    check("ack_port",  32'(a1 ? 1 : 0),  32'(e.port));
                    check("ack_rdata", 32'(get_rdata(i)), 32'(e.data));
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int n;
        int last_t;
        int cs_low;
        int acks;
        bit seen;

        bus0.REQ0 = 1'b0; bus0.REQ1 = 1'b0; bus0.ADDR0 = '0; bus0.ADDR1 = '0;
        bus2.REQ0 = 1'b0; bus2.REQ1 = 1'b0; bus2.ADDR0 = '0; bus2.ADDR1 = '0;
        bus3.REQ0 = 1'b0; bus3.REQ1 = 1'b0; bus3.ADDR0 = '0; bus3.ADDR1 = '0;

        // ---- Reset with both requests high, then contention ----------------
        rst = 1'b1;
        bus0.REQ0 = 1'b1; bus0.ADDR0 = 5'd3;
        bus0.REQ1 = 1'b1; bus0.ADDR1 = 5'd7;
        repeat (3) tick();
        check("rst_cs",    32'(bus0.ROM_CS), 32'd1);
        check("rst_oe",    32'(bus0.ROM_OE), 32'd0);
        check("rst_ack0",  32'(bus0.ACK0),   32'd0);
        check("rst_ack1",  32'(bus0.ACK1),   32'd0);
        check("rst_rdata", 32'(bus0.RDATA),  32'd0);
        check("rst_busy",  32'(bus0.BUSY),   32'd0);
        check("rst_addr",  32'(bus0.ROM_ADDR), 32'd0);

        push(0, 0, 8'h11);
        push(0, 1, 8'h22);
        push(0, 0, 8'h11);
        push(0, 1, 8'h22);
        rst = 1'b0;
        n = 0;
        last_t = 0;
        for (int t = 1; t <= 30 && n < 4; t++) begin
            tick();
            if (bus0.ACK0 || bus0.ACK1) begin
                check("contention_port_order", 32'(bus0.ACK1), 32'(n % 2));
                if (n == 0)
                    check("contention_first_latency", 32'(t), 32'd2);
                else
                    check("contention_spacing", 32'(t - last_t), 32'd3);
                last_t = t;
                n++;
            end
        end
        if (n < 4) timeout_fail("contention_acks");
        bus0.REQ0 = 1'b0;
        bus0.REQ1 = 1'b0;
        repeat (3) tick();
        check("contention_idle_busy", 32'(bus0.BUSY), 32'd0);

        // ---- Single read, zero wait states ---------------------------------
        bus0.REQ0 = 1'b1; bus0.ADDR0 = 5'd5;
        push(0, 0, 8'hA5);
        tick();                                  // edge N: grant
        check("single_rom_addr", 32'(bus0.ROM_ADDR), 32'd5);
        check("single_cs_low",   32'(bus0.ROM_CS),   32'd0);
        check("single_oe_high",  32'(bus0.ROM_OE),   32'd1);
        check("single_busy",     32'(bus0.BUSY),     32'd1);
        tick();                                  // edge N+1: capture
        check("single_ack0",  32'(bus0.ACK0),  32'd1);
        check("single_ack1",  32'(bus0.ACK1),  32'd0);
        check("single_rdata", 32'(bus0.RDATA), 32'hA5);
        check("single_cs_released", 32'(bus0.ROM_CS), 32'd1);
        bus0.REQ0 = 1'b0;
        tick();
        check("single_ack0_pulse", 32'(bus0.ACK0),  32'd0);
        check("single_rdata_hold", 32'(bus0.RDATA), 32'hA5);
        repeat (2) tick();

        // ---- Wait states = 2, top address on requester 1 -------------------
        bus2.REQ1 = 1'b1; bus2.ADDR1 = 5'd31;
        push(2, 1, 8'hFF);
        cs_low = 0;
        seen = 1'b0;
        for (int t = 1; t <= 20 && !seen; t++) begin
            tick();
            if (t == 1) check("ws2_rom_addr", 32'(bus2.ROM_ADDR), 32'd31);
            if (bus2.ROM_CS == 1'b0) cs_low++;
            if (bus2.ACK1) begin
                seen = 1'b1;
                check("ws2_ack_latency", 32'(t), 32'd4);
                check("ws2_rdata", 32'(bus2.RDATA), 32'hFF);
            end
        end
        if (!seen) timeout_fail("ws2_ack");
        check("ws2_cs_low_cycles", 32'(cs_low), 32'd3);
        bus2.REQ1 = 1'b0;
        repeat (3) tick();

        // ---- Abandoned request: REQ0 high for one cycle only ---------------
        bus0.REQ0 = 1'b1; bus0.ADDR0 = 5'd9;
        push(0, 0, 8'h53);
        cs_low = 0;
        acks = 0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 1) bus0.REQ0 = 1'b0;
            if (bus0.ROM_CS == 1'b0) cs_low++;
            if (bus0.ACK0) acks++;
        end
        check("abandon_ack_count", 32'(acks),   32'd1);
        check("abandon_cs_cycles", 32'(cs_low), 32'd1);
        check("abandon_idle",      32'(bus0.BUSY), 32'd0);

        // ---- Reset in the middle of a 3-wait-state access ------------------
        bus3.REQ0 = 1'b1; bus3.ADDR0 = 5'd12;
        tick();                                  // grant, first CS-low cycle
        check("rstmid_cs_low", 32'(bus3.ROM_CS), 32'd0);
        tick();                                  // second CS-low cycle
        rst = 1'b1;
        #1;
        check("rstmid_cs",    32'(bus3.ROM_CS), 32'd1);
        check("rstmid_oe",    32'(bus3.ROM_OE), 32'd0);
        check("rstmid_ack0",  32'(bus3.ACK0),   32'd0);
        check("rstmid_rdata", 32'(bus3.RDATA),  32'd0);
        check("rstmid_busy",  32'(bus3.BUSY),   32'd0);
        repeat (2) tick();
        check("rstmid_no_ack_held", 32'(bus3.ACK0), 32'd0);
        push(3, 0, 8'h56);
        rst = 1'b0;
        seen = 1'b0;
        for (int t = 1; t <= 20 && !seen; t++) begin
            tick();
            if (bus3.ACK0) begin
                seen = 1'b1;
                check("rstmid_reserve_latency", 32'(t), 32'd5);
                check("rstmid_reserve_rdata", 32'(bus3.RDATA), 32'h56);
            end
        end
        if (!seen) timeout_fail("rstmid_reserve_ack");
        bus3.REQ0 = 1'b0;
        repeat (4) tick();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
- Round-robin controller that shares one asynchronous-read ROM between two requesters, e.g. instruction fetch on port 0 and constant/table fetch on port 1.
- Sequences the ROM's active-low chip select, output enable and address bus.
- Registers the returned word and returns it to the granted requester with a one-cycle acknowledge pulse.
- Sits between the processor fetch/load units and the ROM instance.

Parameters:
- WIDTH, 8, ROM data word width in bits.
- DEPTH, 5, ROM address width in bits (2**DEPTH words).
- WAIT_STATES, 0, extra cycles CS/OE are held before sampling ROM data (0..15).

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- REQ0  input  1  requester 0 read request; held until ACK0.
- ADDR0  input  DEPTH  requester 0 address; stable while REQ0 is high.
- REQ1  input  1  requester 1 read request; held until ACK1.
- ADDR1  input  DEPTH  requester 1 address; stable while REQ1 is high.
- ACK0  output  1  one-cycle pulse: RDATA is valid for requester 0.
- ACK1  output  1  one-cycle pulse: RDATA is valid for requester 1.
- RDATA  output  WIDTH  registered read data; holds its value until the next capture.
- BUSY  output  1  high whenever the state is not IDLE.
- ROM_ADDR  output  DEPTH  ROM address bus.
- ROM_CS  output  1  ROM chip select, active-low (1 = deselected, bus tri-stated).
- ROM_OE  output  1  ROM output enable, active-high.
- ROM_DATA  input  WIDTH  ROM data bus.

Behaviour:
- All outputs are registered.
- Reset (async, RST=1) forces:
  - state=IDLE, ROM_CS=1, ROM_OE=0, ROM_ADDR=0, RDATA=0.
  - ACK0=ACK1=0, BUSY=0.
  - wait counter=0, last-grant pointer=1, so requester 0 wins the first tie.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - If no REQ is high, the state stays IDLE with ROM_CS=1 and ROM_OE=0.
  - If exactly one REQ is high, that requester is granted.
  - If both are high, the requester other than the last-grant pointer is granted.
  - On grant at edge N:
    - ROM_ADDR is loaded from that requester's ADDR.
    - ROM_CS goes to 0 and ROM_OE to 1.
    - The wait counter is loaded with WAIT_STATES and the state moves to ACCESS.
    - The grant id is latched.
- ACCESS:
  - While the counter is nonzero, it decrements and outputs are held.
  - When the counter is 0, RDATA is loaded from ROM_DATA.
  - At that same edge, ROM_CS goes to 1, ROM_OE to 0, and the granted requester's ACK goes to 1.
  - The state moves to DONE and the last-grant pointer is set to the grant id.
- DONE:
  - ACK drops to 0 at the next edge and the state moves to IDLE.
  - No arbitration takes place in DONE. This guarantees the requester has dropped or renewed REQ before IDLE samples it.
- Latency and timing, with REQ sampled at edge N:
  - ROM_CS is low for cycles N+1 .. N+1+WAIT_STATES, i.e. WAIT_STATES+1 cycles.
  - RDATA is valid and ACK is high in the cycle after edge N+1+WAIT_STATES.
  - A new grant is possible at edge N+3+WAIT_STATES.
- Back-to-back requests from both requesters alternate grants (0,1,0,1,...). Neither requester is starved.
- A REQ still high in IDLE after its ACK counts as a new request.
- A REQ that drops during ACCESS does not abort the access. ACK is still pulsed and the requester ignores it.
- Changes on the ADDR inputs during ACCESS have no effect, because ROM_ADDR was latched at grant.
- ACK0 and ACK1 are never high in the same cycle.
- ROM_CS=0 always implies ROM_OE=1. The block never drives OE without CS.
- RST asserted mid-access takes effect immediately:
  - CS deasserts with no ACK and RDATA returns to 0.
  - The pending request is re-arbitrated after release if REQ is still high.
- Wait counter width is 4 bits; a WAIT_STATES value outside 0..15 is a parameter error.

Test Plan:
- Reset check: hold RST=1 with REQ0=REQ1=1 -> ROM_CS=1, ROM_OE=0, ACK0=ACK1=0, RDATA=0, BUSY=0. Release RST -> first grant goes to requester 0.
- Single read: ROM preloaded MEMORY[5]=8'hA5, WAIT_STATES=0, REQ0=1 with ADDR0=5 sampled at edge N -> ROM_ADDR=5 and ROM_CS=0 during cycle N+1. ACK0=1 and RDATA=8'hA5 after edge N+1, lasting exactly one cycle. ACK1 stays 0.
- Contention: REQ0 and REQ1 held continuously, ADDR0=3 (8'h11), ADDR1=7 (8'h22) -> ACK sequence 0,1,0,1 with RDATA 11,22,11,22 and one ACK every 3 cycles.
- Wait states: WAIT_STATES=2, REQ1=1 with ADDR1=31 (8'hFF) -> ROM_CS low for exactly 3 cycles, ACK1 4 edges after REQ sampled, RDATA=8'hFF. Also checks the top-address boundary.
- Abandoned request: REQ0 pulsed high for one cycle only -> the full access still completes and ACK0 pulses once. The FSM returns to IDLE with no second access.
- Reset mid-access: WAIT_STATES=3, assert RST during the second cycle of ROM_CS=0 -> ROM_CS=1 and ROM_OE=0 immediately, no ACK, RDATA=0. After release with REQ held, the request is re-served correctly.
